// File: rtl/tang_led_if.sv
// Register-bus connection between a picorv32-style master and the LED controller.
interface tang_led_if;
   logic        sel;
   logic        we;
   logic [3:0]  wstrb;
   logic [2:0]  addr;
   logic [31:0] data_i;
   logic        ready;
   logic [31:0] data_o;

   modport master (output sel, we, wstrb, addr, data_i, input  ready, data_o);
   modport slave  (input  sel, we, wstrb, addr, data_i, output ready, data_o);
endinterface

// File: rtl/tang_led_ctrl.sv
// LED controller: static LED values with per-LED blink and a global PWM brightness,
// configured and read back over a one-cycle registered bus handshake.
module tang_led_ctrl #(
   parameter int unsigned NUM_LEDS   = 6,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned PERIOD_W   = 24
) (
   input  logic                clk,
   input  logic                reset_n,
   tang_led_if.slave           bus,
   output logic [NUM_LEDS-1:0] leds_o
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned PWM_W  = 8;

   localparam logic [2:0] ADDR_VAL    = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd1;
   localparam logic [2:0] ADDR_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_DUTY   = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t              state;
   logic [NUM_LEDS-1:0] led_val;
   logic [NUM_LEDS-1:0] blink_mask;
   logic [PERIOD_W-1:0] blink_period;
   logic [PERIOD_W-1:0] blink_cnt;
   logic                phase;
   logic [PWM_W-1:0]    pwm_duty;
   logic [PWM_W-1:0]    pwm_cnt;

   logic                access_c;
   logic                wr_c;
   logic                period_wr_c;
   logic [DATA_W-1:0]   wmask_c;
   logic [DATA_W-1:0]   rdata_c;
   logic                pwm_on_c;
   logic [NUM_LEDS-1:0] lit_c;

   // Byte-strobe merge of new write data into the current register contents.
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                               input logic [DATA_W-1:0] new_v,
                                               input logic [DATA_W-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   assign access_c    = (state == IDLE) && bus.sel;
   assign wr_c        = access_c && bus.we;
   assign period_wr_c = wr_c && (bus.addr == ADDR_PERIOD) && (|wmask_c[PERIOD_W-1:0]);

   always_comb begin
      wmask_c = '0;
      for (int k = 0; k < 4; k++) begin
         wmask_c[8*k +: 8] = {8{bus.wstrb[k]}};
      end
   end

   assign pwm_on_c = (pwm_cnt < pwm_duty) || (pwm_duty == 8'hFF);
   assign lit_c    = led_val & (~blink_mask | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on_c}};

   always_comb begin
      rdata_c = '0;
      case (bus.addr)
         ADDR_VAL:    rdata_c = DATA_W'(led_val);
         ADDR_MASK:   rdata_c = DATA_W'(blink_mask);
         ADDR_PERIOD: rdata_c = DATA_W'(blink_period);
         ADDR_DUTY:   rdata_c = DATA_W'(pwm_duty);
         ADDR_STATUS: rdata_c = {16'h0000, pwm_cnt, 6'b000000, pwm_on_c, phase};
         default:     rdata_c = '0;
      endcase
   end

   // Handshake: an access in IDLE is acknowledged for exactly one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bus.ready  <= 1'b0;
         bus.data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.sel) begin
                  state     <= ACK;
                  bus.ready <= 1'b1;
                  if (!bus.we) bus.data_o <= rdata_c;
               end
            end
            ACK: begin
               state     <= IDLE;
               bus.ready <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               bus.ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_val      <= '0;
         blink_mask   <= '0;
         blink_period <= '0;
         pwm_duty     <= 8'hFF;
      end else if (wr_c) begin
         case (bus.addr)
            ADDR_VAL:    led_val      <= NUM_LEDS'(merge(DATA_W'(led_val), bus.data_i, wmask_c));
            ADDR_MASK:   blink_mask   <= NUM_LEDS'(merge(DATA_W'(blink_mask), bus.data_i, wmask_c));
            ADDR_PERIOD: blink_period <= PERIOD_W'(merge(DATA_W'(blink_period), bus.data_i, wmask_c));
            ADDR_DUTY:   pwm_duty     <= PWM_W'(merge(DATA_W'(pwm_duty), bus.data_i, wmask_c));
            default:     ;
         endcase
      end
   end

   // Blink engine; a period write restarts the half-period from phase 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (period_wr_c || (blink_period == '0)) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt >= (blink_period - PERIOD_W'(1))) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pwm_cnt <= '0;
      else          pwm_cnt <= pwm_cnt + PWM_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) leds_o <= {NUM_LEDS{ACTIVE_LOW}};
      else          leds_o <= ACTIVE_LOW ? ~lit_c : lit_c;
   end
endmodule
